// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display geometry and the sprite blitter state encoding.
package chip8_pkg;

  localparam int FB_ROW_WORDS = 8;
  localparam int FB_ROWS      = 64;
  localparam int LORES_W      = 64;
  localparam int LORES_H      = 32;
  localparam int HIRES_W      = 128;
  localparam int HIRES_H      = 64;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    BYTE0,
    BYTE1,
    RD0,
    WR0,
    RD1,
    WR1,
    NEXT,
    DONE
  } blit_state_t;

endpackage

// File: rtl/sprite_blit_if.sv
// Sprite blitter bus bundle: CPU command/status, sprite memory read port and framebuffer port.
interface sprite_blit_if #(
  parameter int FB_AW  = 9,
  parameter int MEM_AW = 12
);

  logic              start;
  logic              hires;
  logic [6:0]        x;
  logic [5:0]        y;
  logic [3:0]        n;
  logic [MEM_AW-1:0] iReg;
  logic [MEM_AW-1:0] memAddr;
  logic [7:0]        memData;
  logic [FB_AW-1:0]  fbAddr;
  logic [15:0]       fbRdata;
  logic [15:0]       fbWdata;
  logic              fbWe;
  logic              busy;
  logic              done;
  logic [7:0]        vf;

  modport master (
    output start, hires, x, y, n, iReg, memData, fbRdata,
    input  memAddr, fbAddr, fbWdata, fbWe, busy, done, vf
  );

  modport slave (
    input  start, hires, x, y, n, iReg, memData, fbRdata,
    output memAddr, fbAddr, fbWdata, fbWe, busy, done, vf
  );

endinterface

// File: rtl/sprite_shift.sv
// Places a left-aligned sprite row at a pixel offset inside a two-word window.
module sprite_shift (
  input  logic [15:0] pattern,
  input  logic [3:0]  offset,
  output logic [15:0] mask0,
  output logic [15:0] mask1
);

  logic [31:0] window;

  assign window = {pattern, 16'h0000} >> offset;
  assign mask0  = window[31:16];
  assign mask1  = window[15:0];

endmodule

// File: rtl/sprite_blit.sv
// CHIP-8 DXYN draw engine: XORs sprite rows into the word framebuffer and reports VF.
// Build option SCHIP_ROWCOUNT_EN: hires VF counts collided rows plus rows clipped at the bottom.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | present first sprite byte address
// BYTE0 | capture first byte; present second byte address when 16 wide
// BYTE1 | capture second byte
// RD0   | read left framebuffer word
// WR0   | write left word back with sprite XORed in
// RD1   | read right framebuffer word
// WR1   | write right word back
// NEXT  | row bookkeeping, decide next row or finish
// DONE  | completion pulse, vf valid
module sprite_blit
  import chip8_pkg::*;
#(
  parameter int FB_AW  = 9,
  parameter int MEM_AW = 12
) (
  input logic          clk,
  input logic          rst_n,
  sprite_blit_if.slave bus
);

  blit_state_t       state, nextState;
  logic              hiresL, wideL, rowHit;
  logic [6:0]        xL, rowY, height;
  logic [4:0]        rowsLeft, hitRows, hitTotal;
  logic [MEM_AW-1:0] memPtr;
  logic [15:0]       pat, mask0, mask1;
  logic [7:0]        vfReg, vfResult;
  logic [2:0]        word0;
  logic [3:0]        word1, wordLimit;
  logic              lastRow, clipNext, finish, word1Ok;

  sprite_shift uShift (
    .pattern (pat),
    .offset  (xL[3:0]),
    .mask0   (mask0),
    .mask1   (mask1)
  );

  assign word0     = xL[6:4];
  assign word1     = {1'b0, word0} + 4'd1;
  assign wordLimit = hiresL ? 4'(HIRES_W / 16) : 4'(LORES_W / 16);
  assign height    = hiresL ? 7'(HIRES_H) : 7'(LORES_H);
  assign word1Ok   = (mask1 != 16'h0000) && (word1 < wordLimit);
  assign lastRow   = rowsLeft == 5'd1;
  assign clipNext  = (rowY + 7'd1) >= height;
  assign finish    = lastRow || clipNext;
  assign hitTotal  = hitRows + {4'd0, rowHit};

`ifdef SCHIP_ROWCOUNT_EN
  logic [4:0] clipRows;
  assign clipRows = lastRow ? 5'd0 : rowsLeft - 5'd1;
  assign vfResult = hiresL ? 8'(hitTotal + clipRows) : {7'd0, hitTotal != 5'd0};
`else
  assign vfResult = {7'd0, hitTotal != 5'd0};
`endif

  always_comb begin
    nextState   = state;
    bus.memAddr = '0;
    bus.fbAddr  = '0;
    bus.fbWdata = '0;
    bus.fbWe    = 1'b0;
    case (state)
      IDLE:  if (bus.start) nextState = FETCH;
      FETCH: begin
        bus.memAddr = memPtr;
        nextState   = BYTE0;
      end
      BYTE0: begin
        if (wideL) begin
          bus.memAddr = memPtr + MEM_AW'(1);
          nextState   = BYTE1;
        end else begin
          nextState   = RD0;
        end
      end
      BYTE1: nextState = RD0;
      RD0: begin
        bus.fbAddr = FB_AW'({rowY[5:0], word0});
        nextState  = WR0;
      end
      // address held from the read cycle so the write lands on the word just read
      WR0: begin
        bus.fbAddr  = FB_AW'({rowY[5:0], word0});
        bus.fbWe    = 1'b1;
        bus.fbWdata = bus.fbRdata ^ mask0;
        nextState   = word1Ok ? RD1 : NEXT;
      end
      RD1: begin
        bus.fbAddr = FB_AW'({rowY[5:0], word1[2:0]});
        nextState  = WR1;
      end
      WR1: begin
        bus.fbAddr  = FB_AW'({rowY[5:0], word1[2:0]});
        bus.fbWe    = 1'b1;
        bus.fbWdata = bus.fbRdata ^ mask1;
        nextState   = NEXT;
      end
      NEXT:    nextState = finish ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE) && (state != DONE);
  assign bus.done = state == DONE;
  assign bus.vf   = vfReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hiresL   <= 1'b0;
      wideL    <= 1'b0;
      xL       <= '0;
      rowY     <= '0;
      rowsLeft <= '0;
      memPtr   <= '0;
      pat      <= '0;
      rowHit   <= 1'b0;
      hitRows  <= '0;
      vfReg    <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (bus.start) begin
            hiresL   <= bus.hires;
            wideL    <= bus.hires && (bus.n == 4'd0);
            xL       <= bus.hires ? bus.x : {1'b0, bus.x[5:0]};
            rowY     <= bus.hires ? {1'b0, bus.y} : {2'b00, bus.y[4:0]};
            rowsLeft <= (bus.n == 4'd0) ? 5'd16 : {1'b0, bus.n};
            memPtr   <= bus.iReg;
            rowHit   <= 1'b0;
            hitRows  <= '0;
            vfReg    <= '0;
          end
        end
        BYTE0: pat       <= {bus.memData, 8'h00};
        BYTE1: pat[7:0]  <= bus.memData;
        WR0:   rowHit    <= rowHit | (|(bus.fbRdata & mask0));
        WR1:   rowHit    <= rowHit | (|(bus.fbRdata & mask1));
        NEXT: begin
          hitRows  <= hitTotal;
          rowHit   <= 1'b0;
          memPtr   <= memPtr + (wideL ? MEM_AW'(2) : MEM_AW'(1));
          rowY     <= rowY + 7'd1;
          rowsLeft <= rowsLeft - 5'd1;
          if (finish) vfReg <= vfResult;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit with a pixel-level reference model and per-write checking.
`timescale 1ns/1ps
module tb_sprite_blit;

`ifdef SCHIP_ROWCOUNT_EN
  localparam bit SCHIP = 1'b1;
`else
  localparam bit SCHIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   fbInit = 1'b1;

  sprite_blit_if #(.FB_AW(9), .MEM_AW(12)) bus ();

  sprite_blit #(.FB_AW(9), .MEM_AW(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem   [4096];
  logic [15:0] fbMem [512];
  logic [15:0] refFb [512];
  logic [24:0] expQ  [$];
  int errors = 0;
  int checks = 0;
  int wrTotal = 0;

  always @(posedge clk) begin
    bus.memData <= mem[bus.memAddr];
    bus.fbRdata <= fbMem[bus.fbAddr];
    if (fbInit) begin
      for (int i = 0; i < 512; i++) fbMem[i] <= 16'h0000;
    end else if (bus.fbWe) begin
      fbMem[bus.fbAddr] <= bus.fbWdata;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: toggle each lit pixel of the sprite, row by row, in refFb.
  task automatic plan(input bit hr, input int xi, input int yi, input int ni, input int base,
                      output int expVf, output int nWr);
    int w, h, xs, ys, rows, wpx, hits, drawn;
    logic [15:0] bits;
    logic [15:0] m [8];
    w = hr ? 128 : 64;
    h = hr ? 64 : 32;
    xs = xi % w;
    ys = yi % h;
    rows = (ni == 0) ? 16 : ni;
    wpx = (hr && ni == 0) ? 16 : 8;
    hits = 0;
    drawn = 0;
    nWr = 0;
    for (int r = 0; r < rows; r++) begin
      int py, w0, w1, a;
      bit hit;
      py = ys + r;
      if (py >= h) break;
      drawn++;
      if (wpx == 16) bits = {mem[base + 2*r], mem[base + 2*r + 1]};
      else           bits = {mem[base + r], 8'h00};
      for (int k = 0; k < 8; k++) m[k] = 16'h0000;
      for (int c = 0; c < wpx; c++) begin
        int px;
        px = xs + c;
        if (bits[15-c] && px < w) m[px/16][15 - (px % 16)] = 1'b1;
      end
      w0 = xs / 16;
      w1 = w0 + 1;
      a = py*8 + w0;
      hit = |(refFb[a] & m[w0]);
      expQ.push_back({9'(a), refFb[a] ^ m[w0]});
      refFb[a] = refFb[a] ^ m[w0];
      nWr++;
      if (w1 < w/16 && m[w1] != 16'h0000) begin
        a = py*8 + w1;
        hit = hit | (|(refFb[a] & m[w1]));
        expQ.push_back({9'(a), refFb[a] ^ m[w1]});
        refFb[a] = refFb[a] ^ m[w1];
        nWr++;
      end
      if (hit) hits++;
    end
    if (hr && SCHIP) expVf = hits + (rows - drawn);
    else             expVf = (hits > 0) ? 1 : 0;
  endtask

  task automatic draw(input bit hr, input int xi, input int yi, input int ni, input int base,
                      output int vfOut, output int nWr);
    int expVf, expWr, wr0, bad;
    bit seen;
    plan(hr, xi, yi, ni, base, expVf, expWr);
    @(negedge clk);
    bus.hires = hr;
    bus.x     = 7'(xi);
    bus.y     = 6'(yi);
    bus.n     = 4'(ni);
    bus.iReg  = 12'(base);
    bus.start = 1'b1;
    wr0 = wrTotal;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_within_bound", 32'(seen), 32'd1);
    check("vf_model", 32'(bus.vf), 32'(expVf));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("write_count", 32'(wrTotal - wr0), 32'(expWr));
    check("pending_writes", 32'(expQ.size()), 32'd0);
    expQ.delete();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 512; i++) if (fbMem[i] !== refFb[i]) bad++;
    check("fb_image_words_wrong", 32'(bad), 32'd0);
    vfOut = bus.vf;
    nWr = wrTotal - wr0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v, nw, cnt;
    bus.start = 1'b0;
    bus.hires = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.n     = '0;
    bus.iReg  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 512; i++)  refFb[i] = 16'h0000;
    mem[12'h200] = 8'hF0;
    mem[12'h210] = 8'hFF;
    mem[12'h211] = 8'h81;
    mem[12'h220] = 8'h80;
    mem[12'h221] = 8'h80;
    mem[12'h222] = 8'h80;
    for (int i = 0; i < 32; i++) mem[12'h230 + i] = 8'hFF;

    repeat (3) @(negedge clk);
    fbInit = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_vf", 32'(bus.vf), 32'd0);
    check("rst_fbWe", 32'(bus.fbWe), 32'd0);
    check("rst_memAddr", 32'(bus.memAddr), 32'd0);
    check("rst_fbAddr", 32'(bus.fbAddr), 32'd0);
    check("rst_fbWdata", 32'(bus.fbWdata), 32'd0);
    rst_n = 1'b1;

    fork
      forever begin
        logic [24:0] e;
        @(negedge clk);
        if (rst_n && bus.fbWe) begin
          wrTotal++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bus.fbAddr, bus.fbWdata);
          end else begin
            e = expQ.pop_front();
            check("fb_write_addr", 32'(bus.fbAddr), 32'(e[24:16]));
            check("fb_write_data", 32'(bus.fbWdata), 32'(e[15:0]));
          end
        end
      end
    join_none

    draw(1'b0, 0, 0, 1, 12'h200, v, nw);
    check("lit_lo_word0", 32'(fbMem[0]), 32'h0000F000);
    check("lit_lo_word1", 32'(fbMem[1]), 32'h0);
    check("lit_lo_vf", 32'(v), 32'd0);

    draw(1'b0, 0, 0, 1, 12'h200, v, nw);
    check("lit_redraw_word0", 32'(fbMem[0]), 32'h0);
    check("lit_redraw_vf", 32'(v), 32'd1);

    draw(1'b0, 12, 2, 1, 12'h210, v, nw);
    check("lit_x12_word0", 32'(fbMem[16]), 32'h000F);
    check("lit_x12_word1", 32'(fbMem[17]), 32'hF000);
    check("lit_x12_writes", 32'(nw), 32'd2);

    draw(1'b1, 127, 63, 3, 12'h220, v, nw);
    check("lit_corner_word", 32'(fbMem[63*8 + 7]), 32'h0001);
    check("lit_corner_writes", 32'(nw), 32'd1);
    check("lit_corner_vf", 32'(v), SCHIP ? 32'd2 : 32'd0);

    draw(1'b1, 8, 10, 0, 12'h230, v, nw);
    check("lit_big_r10_w0", 32'(fbMem[80]), 32'h00FF);
    check("lit_big_r10_w1", 32'(fbMem[81]), 32'hFF00);
    check("lit_big_r25_w1", 32'(fbMem[25*8 + 1]), 32'hFF00);
    check("lit_big_r26_w0", 32'(fbMem[26*8]), 32'h0);
    check("lit_big_writes", 32'(nw), 32'd32);
    check("lit_big_vf", 32'(v), 32'd0);

    draw(1'b1, 8, 10, 0, 12'h230, v, nw);
    check("lit_big_erase", 32'(fbMem[81]), 32'h0);
    check("lit_big_redraw_vf", 32'(v), SCHIP ? 32'd16 : 32'd1);

    draw(1'b0, 70, 5, 2, 12'h210, v, nw);
    check("lit_wrap_r5", 32'(fbMem[40]), 32'h03FC);
    check("lit_wrap_r6", 32'(fbMem[48]), 32'h0204);

    draw(1'b0, 60, 31, 2, 12'h210, v, nw);
    check("lit_lo_edge_word3", 32'(fbMem[31*8 + 3]), 32'h000F);
    check("lit_lo_edge_writes", 32'(nw), 32'd1);
    check("lit_lo_edge_vf", 32'(v), 32'd0);

    plan(1'b1, 8, 40, 0, 12'h230, v, nw);
    @(negedge clk);
    bus.hires = 1'b1;
    bus.x     = 7'd8;
    bus.y     = 6'd40;
    bus.n     = 4'd0;
    bus.iReg  = 12'h230;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_vf", 32'(bus.vf), 32'd0);
    check("abort_fbWe", 32'(bus.fbWe), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.fbWe || bus.busy) cnt++;
    end
    check("abort_quiet_cycles", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
